// File: rtl/hist_pkg.sv
// hist_pkg
//   Shared definitions for the per-pixel TOF histogram peak finder:
//   parameter defaults, the frame-level state enum and the no-hit
//   code detector used on incoming timestamps.
package hist_pkg;

    localparam int NP_DEF       = 10;
    localparam int BIN_BITS_DEF = 5;
    localparam int PIXELS_DEF   = 3;
    localparam int HITS_DEF     = 2;
    localparam int ACQ_NUM_DEF  = 2;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // A timestamp whose low np bits are all ones means "no hit".
    function automatic logic is_no_hit(input logic [31:0] data, input int np);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i < np) && !data[i]) begin
                all_ones = 1'b0;
            end
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/hist_ram.sv
// hist_ram
//   Simple dual-port histogram storage: one write port, one read port,
//   read data registered (one cycle latency). A read and write to the
//   same address in the same cycle returns the old contents; the caller
//   handles forwarding.
// Ports
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (sampled every cycle)
//   rdata  : registered read data
module hist_ram #(
    parameter int DEPTH = 96,
    parameter int AW    = 7,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hist_peak_builder.sv
// hist_peak_builder
//   Builds one histogram per pixel from a stream of TOF timestamps,
//   tracks the peak bin of each pixel while accumulating, and reports
//   (pixel, peak bin, peak count) for every pixel at the end of a frame.
//   Frame flow: CLEAR (zero RAM) -> ACCUM (take samples) -> REPORT.
// Ports
//   clk       : clock, rising edge
//   res       : synchronous active-high reset
//   in_valid  : in_data qualifier
//   in_ready  : block accepts a sample this cycle
//   in_data   : TOF timestamp, all ones = no hit
//   out_valid : result qualifier
//   out_ready : consumer accepts result
//   out_pixel : pixel index of result
//   out_bin   : peak bin of that pixel
//   out_count : peak count of that pixel
module hist_peak_builder
    import hist_pkg::*;
#(
    parameter int NP       = NP_DEF,
    parameter int BIN_BITS = BIN_BITS_DEF,
    parameter int PIXELS   = PIXELS_DEF,
    parameter int HITS     = HITS_DEF,
    parameter int ACQ_NUM  = ACQ_NUM_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int PW      = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic                clk,
    input  logic                res,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NP-1:0]       in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PW-1:0]       out_pixel,
    output logic [BIN_BITS-1:0] out_bin,
    output logic [CNT_W-1:0]    out_count
);

    localparam int NBINS = 2 ** BIN_BITS;
    localparam int DEPTH = PIXELS * NBINS;
    localparam int AW    = PW + BIN_BITS;
    localparam int TOTAL = PIXELS * HITS * ACQ_NUM;
    localparam int SW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int HW    = (HITS > 1) ? $clog2(HITS) : 1;

    state_t              state_q;
    logic [AW-1:0]       clr_addr_q;
    logic                in_ready_q;
    logic [SW-1:0]       sample_q;
    logic [HW-1:0]       hit_q;
    logic [PW-1:0]       pix_q;
    logic [HW-1:0]       hit_d;
    logic [PW-1:0]       pix_d;

    // Stage 1: sample accepted last cycle, RAM read data now available.
    logic                s1_valid_q;
    logic [AW-1:0]       s1_addr_q;
    // Last committed increment, for read-after-write forwarding.
    logic                lw_valid_q;
    logic [AW-1:0]       lw_addr_q;
    logic [CNT_W-1:0]    lw_data_q;

    logic [CNT_W-1:0]    peak_cnt_q [PIXELS];
    logic [BIN_BITS-1:0] peak_bin_q [PIXELS];
    logic [PIXELS-1:0]   peak_upd;

    logic [PW-1:0]       rpt_q;
    logic [PW-1:0]       rpt_d;
    logic                out_valid_q;
    logic [PW-1:0]       out_pixel_q;
    logic [BIN_BITS-1:0] out_bin_q;
    logic [CNT_W-1:0]    out_count_q;

    logic                accept;
    logic                in_hit;
    logic [AW-1:0]       rd_addr;
    logic [CNT_W-1:0]    ram_rdata;
    logic [CNT_W-1:0]    base_cnt;
    logic [CNT_W-1:0]    inc_cnt;
    logic                ram_we;
    logic [AW-1:0]       ram_waddr;
    logic [CNT_W-1:0]    ram_wdata;

    assign accept  = in_valid && in_ready_q;
    assign in_hit  = accept && !is_no_hit(32'(in_data), NP);
    assign rd_addr = {pix_q, in_data[NP-1 -: BIN_BITS]};

    // The RAM read issued last cycle misses a write committed in that same
    // cycle; substitute the committed value when the addresses match.
    assign base_cnt = (lw_valid_q && (lw_addr_q == s1_addr_q)) ? lw_data_q : ram_rdata;
    assign inc_cnt  = (base_cnt == {CNT_W{1'b1}}) ? base_cnt : base_cnt + 1'b1;

    // A pending increment is dropped when reset hits in the same cycle.
    assign ram_we    = !res && ((state_q == CLEAR) || s1_valid_q);
    assign ram_waddr = (state_q == CLEAR) ? clr_addr_q : s1_addr_q;
    assign ram_wdata = (state_q == CLEAR) ? '0 : inc_cnt;

    assign hit_d = (hit_q == HW'(HITS - 1)) ? '0 : hit_q + 1'b1;
    assign pix_d = (hit_q != HW'(HITS - 1)) ? pix_q :
                   (pix_q == PW'(PIXELS - 1)) ? '0 : pix_q + 1'b1;
    assign rpt_d = rpt_q + 1'b1;

    hist_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Strictly greater: on a tie the bin that reached the count first stays.
    for (genvar gi = 0; gi < PIXELS; gi++) begin : g_peak
        assign peak_upd[gi] = s1_valid_q
                              && (s1_addr_q[AW-1:BIN_BITS] == PW'(gi))
                              && (inc_cnt > peak_cnt_q[gi]);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PIXELS; i++) begin
            if (res || (state_q == CLEAR)) begin
                peak_cnt_q[i] <= '0;
                peak_bin_q[i] <= '0;
            end else if (peak_upd[i]) begin
                peak_cnt_q[i] <= inc_cnt;
                peak_bin_q[i] <= s1_addr_q[BIN_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            in_ready_q  <= 1'b0;
            sample_q    <= '0;
            hit_q       <= '0;
            pix_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            lw_valid_q  <= 1'b0;
            lw_addr_q   <= '0;
            lw_data_q   <= '0;
            rpt_q       <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_bin_q   <= '0;
            out_count_q <= '0;
        end else begin
            s1_valid_q <= 1'b0;
            lw_valid_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    sample_q <= '0;
                    hit_q    <= '0;
                    pix_q    <= '0;
                    if (clr_addr_q == AW'(DEPTH - 1)) begin
                        clr_addr_q <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= ACCUM;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                ACCUM: begin
                    s1_valid_q <= in_hit;
                    s1_addr_q  <= rd_addr;
                    lw_valid_q <= s1_valid_q;
                    lw_addr_q  <= s1_addr_q;
                    lw_data_q  <= inc_cnt;
                    if (accept) begin
                        sample_q <= sample_q + 1'b1;
                        hit_q    <= hit_d;
                        pix_q    <= pix_d;
                        if (sample_q == SW'(TOTAL - 1)) begin
                            in_ready_q <= 1'b0;
                        end
                    end
                    // in_ready low here means the last sample's write is
                    // committing this cycle, so peaks are final next cycle.
                    if (!in_ready_q) begin
                        state_q <= REPORT;
                        rpt_q   <= '0;
                    end
                end
                REPORT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_pixel_q <= rpt_q;
                        out_bin_q   <= peak_bin_q[rpt_q];
                        out_count_q <= peak_cnt_q[rpt_q];
                    end else if (out_ready) begin
                        if (rpt_q == PW'(PIXELS - 1)) begin
                            out_valid_q <= 1'b0;
                            out_pixel_q <= '0;
                            out_bin_q   <= '0;
                            out_count_q <= '0;
                            rpt_q       <= '0;
                            clr_addr_q  <= '0;
                            state_q     <= CLEAR;
                        end else begin
                            rpt_q       <= rpt_d;
                            out_pixel_q <= rpt_d;
                            out_bin_q   <= peak_bin_q[rpt_d];
                            out_count_q <= peak_cnt_q[rpt_d];
                        end
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_bin   = out_bin_q;
    assign out_count = out_count_q;

endmodule

// File: doc/hist_peak_builder.md
HIST_PEAK_BUILDER -- requirements
Module: hist_peak_builder

Interface
REQ-001 SHALL have parameter NP, 10, timestamp width in bits.
REQ-002 SHALL have parameter BIN_BITS, 5, histogram bin index width; bin = data[NP-1 -: BIN_BITS]; NBINS = 2**BIN_BITS.
REQ-003 SHALL have parameter PIXELS, 3, pixels sharing one histogram RAM.
REQ-004 SHALL have parameter HITS, 2, timestamps per pixel per acquisition.
REQ-005 SHALL have parameter ACQ_NUM, 2, acquisitions accumulated per frame.
REQ-006 SHALL have parameter CNT_W, 8, bin counter width.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-008 SHALL have port res, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_valid, input, 1, in_data qualifier.
REQ-010 SHALL have port in_ready, output, 1, block accepts a sample.
REQ-011 SHALL have port in_data, input, NP, TOF timestamp; all-ones = no-hit code.
REQ-012 SHALL have port out_valid, output, 1, result qualifier.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-014 SHALL have port out_pixel, output, clog2(PIXELS), pixel index of result.
REQ-015 SHALL have port out_bin, output, BIN_BITS, peak bin.
REQ-016 SHALL have port out_count, output, CNT_W, peak count.

Function
REQ-017 SHALL run states CLEAR -> ACCUM -> REPORT -> CLEAR.
REQ-018 CLEAR SHALL write zero to all PIXELS*NBINS entries, one per cycle, addr 0 upward; in_ready=0; per-pixel peak regs zeroed; then ACCUM.
REQ-019 ACCUM SHALL hold in_ready=1; sample accepted when in_valid&&in_ready.
REQ-020 Sample order SHALL be acquisition-major, then pixel, then hit; pixel = (accept index / HITS) mod PIXELS.
REQ-021 Accepted non-no-hit sample SHALL read entry {pixel,bin} in accept cycle t, write saturating count+1 in t+1 (count at 2**CNT_W-1 unchanged).
REQ-022 Back-to-back accepts to the same entry SHALL forward the in-flight write value; no lost increments at full rate.
REQ-023 No-hit sample (all-ones) SHALL advance the sample counter without touching RAM or peak.
REQ-024 Peak per pixel SHALL update at t+1 when new count > stored peak count (strict; ties keep earlier-reaching bin); pixel with no hits reports bin 0, count 0.
REQ-025 After PIXELS*HITS*ACQ_NUM accepts, in_ready SHALL drop the next cycle; REPORT entered after the last write commits (at most 2 cycles after last accept).
REQ-026 REPORT SHALL present pixels 0..PIXELS-1 in order, one per out_valid&&out_ready handshake; outputs stable while out_valid&&!out_ready.
REQ-027 After last REPORT handshake SHALL enter CLEAR next cycle, out_valid=0.

Reset
REQ-028 res SHALL force CLEAR from clear address 0, sample/pixel/report counters 0, in_ready=0, out_valid=0, out_pixel/out_bin/out_count=0, in any state, including mid-ACCUM or mid-REPORT; pending write discarded.
REQ-029 First ACCUM cycle SHALL occur PIXELS*NBINS cycles after res deasserts.

Structure
REQ-030 Package hist_pkg SHALL hold parameter defaults, state enum (CLEAR, ACCUM, REPORT), no-hit code function.
REQ-031 Sub-module hist_ram SHALL be a 1-read/1-write synchronous-read RAM, PIXELS*NBINS x CNT_W; forwarding lives in hist_peak_builder.

Verification (defaults unless stated)
REQ-032 res 1 cycle -> in_ready=0 for exactly 96 cycles, then 1.
REQ-033 Pixel0 all four samples 108 (bin 3), others 1023 -> results (0,3,4),(1,0,0),(2,0,0).
REQ-034 Pixel1 samples 288,288 acq0 then 288,128 acq1, in_valid held high -> (1,9,3) proving forwarding; tie case pixel2 288,288,128,128 -> (2,9,2).
REQ-035 CNT_W=2, pixel0 four 108, ACQ_NUM=4 -> out_count=3 (saturated).
REQ-036 out_ready low 5 cycles during REPORT -> out_valid/data stable; res asserted mid-REPORT -> out_valid 0 next cycle, 96-cycle clear, new frame correct.
